// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_DM = 2'd1,
    BUSY_IF = 2'd2
  } arb_state_e;

  // Port indices into the per-port buffer arrays.
  localparam int PORT_IF  = 0;
  localparam int PORT_DM  = 1;
  localparam int NUM_PORTS = 2;

  localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_port_buf.sv
// One requester's sticky ready flag and held read data.
module mem_arb_port_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              set_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Set beats clear so a completion landing on a non-stall cycle is still seen once.
  always_comb begin
    ready_d = ready_q;
    rdata_d = rdata_q;
    if (clr_i) ready_d = 1'b0;
    if (set_i) begin
      ready_d = 1'b1;
      rdata_d = rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  assign ready_o = ready_q;
  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-ported unified memory with a global pipeline stall.
// Optional ack timeout enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i32,
  output logic [DATA_W-1:0] if_rdata_o32,
  output logic              if_ready_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i32,
  input  logic [DATA_W-1:0] dm_wdata_i32,
  output logic [DATA_W-1:0] dm_rdata_o32,
  output logic              dm_ready_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o32,
  output logic [DATA_W-1:0] mem_wdata_o32,
  input  logic [DATA_W-1:0] mem_rdata_i32,
  input  logic              mem_ack_i,
  output logic              err_o
);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done, tmo;
  logic [DATA_W-1:0] fill;

  logic [NUM_PORTS-1:0]             req, ready, buf_set;
  logic [NUM_PORTS-1:0][DATA_W-1:0] buf_rdata_in, buf_rdata_out;

  assign req[PORT_IF] = if_req_i;
  assign req[PORT_DM] = dm_req_i;
  assign stall_o      = |(req & ~ready);

  always_comb begin
    state_d   = state_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        // Data side belongs to the older instruction, so it goes first.
        if (dm_req_i && !ready[PORT_DM]) begin
          state_d   = BUSY_DM;
          mem_req_d = 1'b1;
          mem_we_d  = dm_we_i;
          addr_d    = dm_addr_i32;
          wdata_d   = dm_wdata_i32;
        end else if (if_req_i && !ready[PORT_IF]) begin
          state_d   = BUSY_IF;
          mem_req_d = 1'b1;
          addr_d    = if_addr_i32;
        end
      end
      BUSY_DM, BUSY_IF: begin
        if (mem_ack_i || tmo) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          done      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign mem_req_o     = mem_req_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o32  = addr_q;
  assign mem_wdata_o32 = wdata_q;

  assign fill = mem_ack_i ? mem_rdata_i32 : DATA_W'(TIMEOUT_FILL);

  assign buf_set[PORT_IF]      = done && (state_q == BUSY_IF);
  assign buf_set[PORT_DM]      = done && (state_q == BUSY_DM);
  assign buf_rdata_in[PORT_IF] = fill;
  // A completed store leaves the held load data untouched.
  assign buf_rdata_in[PORT_DM] = (mem_we_q && mem_ack_i) ? buf_rdata_out[PORT_DM] : fill;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    mem_arb_port_buf #(.DATA_W(DATA_W)) u_buf (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .set_i   (buf_set[p]),
      .clr_i   (~stall_o),
      .rdata_i (buf_rdata_in[p]),
      .ready_o (ready[p]),
      .rdata_o (buf_rdata_out[p])
    );
  end

  assign if_ready_o   = ready[PORT_IF];
  assign dm_ready_o   = ready[PORT_DM];
  assign if_rdata_o32 = buf_rdata_out[PORT_IF];
  assign dm_rdata_o32 = buf_rdata_out[PORT_DM];

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Count runs from zero on the first busy cycle; IDLE holds it cleared.
  assign tmo   = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign cnt_d = (state_q == IDLE) ? '0 : cnt_q + CNT_W'(1);
  assign err_d = err_q | (tmo & ~mem_ack_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYC;
  assign tmo            = 1'b0;
  assign err_o          = 1'b0;
`endif

endmodule
